// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch constants: datapath widths, PC step and reset vector.
// Pure definitions; no logic, no latency, no flow control.
// Word alignment helper used on every PC load.
package riscv_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Generic W-bit FIFO of DEPTH slots with flush and occupancy count.
// Head visible combinationally (zero when empty); push and pop may share a cycle.
// Push when full / pop when empty are ignored; the caller owns flow control.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop  && (r_cnt != '0);
    assign w_push = i_push && (r_cnt != (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wr] <= i_push_dat;
    end

    assign o_dat   = (r_cnt == '0) ? '0 : r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited request issue, PC-tagged in-order response buffer, redirect drain.
// Response to inst_valid in 1 cycle; first request in the cycle after reset release.
// Requests stall while buffer plus in-flight reaches DEPTH; FETCH_PERF_CNT_EN adds perf counters.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [XLEN-1:0]    inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [CW-1:0]           w_buf_cnt;
    logic [CW-1:0]           w_tag_cnt;
    logic [CW-1:0]           r_drop_cnt;
    logic [XLEN-1:0]         r_pc;
    logic [XLEN-1:0]         w_tag_head;
    logic [XLEN+INSTR_W-1:0] w_buf_head;
    logic                    r_run;
    logic                    w_pop;
    logic                    w_req_fire;
    logic                    w_resp_keep;
    logic                    w_resp_drop;
    logic [SW-1:0]           w_inflight;
    logic [SW-1:0]           w_used;

    assign inst_valid = (w_buf_cnt != '0);
    assign w_pop      = inst_valid && inst_ready;

    // Dropped requests still hold a credit; a same-cycle pop frees its slot so streaming has no bubble.
    assign w_inflight     = SW'(w_tag_cnt) + SW'(r_drop_cnt);
    assign w_used         = SW'(w_buf_cnt) + w_inflight - SW'(w_pop);
    assign imem_req_valid = r_run && (w_used < SW'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
    assign w_resp_keep = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;

    fetch_fifo #(.W(XLEN + INSTR_W), .DEPTH(DEPTH)) u_inst_buf (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (redirect_valid),
        .i_push     (w_resp_keep),
        .i_push_dat ({w_tag_head, imem_resp_data}),
        .i_pop      (w_pop),
        .o_dat      (w_buf_head),
        .o_count    (w_buf_cnt)
    );

    fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_tags (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (redirect_valid),
        .i_push     (w_req_fire),
        .i_push_dat (r_pc),
        .i_pop      (w_resp_keep),
        .o_dat      (w_tag_head),
        .o_count    (w_tag_cnt)
    );

    assign {inst_pc, inst_data} = w_buf_head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_pc       <= word_align(RESET_PC);
            r_drop_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_pc <= word_align(redirect_pc);
                // Everything in flight becomes stale, including a request accepted this cycle.
                r_drop_cnt <= CW'(w_inflight + SW'(w_req_fire) - SW'(imem_resp_valid));
            end else begin
                if (w_req_fire)  r_pc <= r_pc + PC_INC;
                if (w_resp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (inst_ready && !inst_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (redirect_valid && (flush_count != '1))             flush_count  <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences, and
// randomized traffic checked against a queue-based reference model of the fetch rules.
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rr;
        bit          ir;
        bit          rd;
        logic [31:0] rpc;
        bit          erv;
        logic [31:0] ea;
        bit          eiv;
        logic [31:0] eipc;
    } vec_t;
    typedef struct { logic [31:0] pc; logic [31:0] dat; } ent_t;
    typedef struct { logic [31:0] pc; bit live; } fly_t;
    typedef struct { int due; logic [31:0] addr; } mrsp_t;

    ent_t        mbuf[$];
    fly_t        mfly[$];
    mrsp_t       pend[$];
    logic [31:0] mpc;
    bit          mrun, m_init;
    bit          e_rv, e_pop;
    logic [31:0] mstall;
    logic [15:0] mflush;
    int          cyc, lat, last_due;
    int          n_total, n_bad;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_ipc, s_idat, s_stall;
    logic [15:0] s_flush;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t v(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc,
                               input bit erv, input logic [31:0] ea, input bit eiv, input logic [31:0] eipc);
        vec_t t;
        t = '{rr, ir, rd, rpc, erv, ea, eiv, eipc};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_check();
        bit          eiv;
        logic [31:0] epc, edat;
        s_rv   = imem_req_valid;
        s_iv   = inst_valid;
        s_addr = imem_req_addr;
        s_ipc  = inst_pc;
        s_idat = inst_data;
`ifdef FETCH_PERF_CNT_EN
        s_stall = stall_cycles;
        s_flush = flush_count;
`else
        s_stall = '0;
        s_flush = '0;
`endif
        e_rv  = 1'b0;
        e_pop = 1'b0;
        if (m_init) begin
            eiv   = mbuf.size() > 0;
            epc   = eiv ? mbuf[0].pc  : 32'h0;
            edat  = eiv ? mbuf[0].dat : 32'h0;
            e_pop = eiv && inst_ready;
            e_rv  = mrun && (mbuf.size() - int'(e_pop) + mfly.size() < DEPTH);
            chk("m_req_valid", {31'd0, s_rv}, {31'd0, e_rv});
            chk("m_req_addr", s_addr, mpc);
            chk("m_inst_valid", {31'd0, s_iv}, {31'd0, eiv});
            chk("m_inst_pc", s_ipc, epc);
            chk("m_inst_data", s_idat, edat);
`ifdef FETCH_PERF_CNT_EN
            chk("m_stall", s_stall, mstall);
            chk("m_flush", {16'd0, s_flush}, {16'd0, mflush});
`endif
        end
    endtask

    task automatic model_update(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
        fly_t f;
        int   due;
        if (!rst) begin
            mbuf.delete(); mfly.delete(); pend.delete();
            mpc = RESET_PC; mrun = 1'b0; m_init = 1'b1;
            mstall = '0; mflush = '0; last_due = 0;
        end else if (m_init) begin
            if (ir && mbuf.size() == 0) mstall++;
            if (rd) mflush++;
            if (e_pop) void'(mbuf.pop_front());
            if (imem_resp_valid && mfly.size() > 0) begin
                f = mfly.pop_front();
                if (f.live && !rd) mbuf.push_back('{f.pc, imem_resp_data});
            end
            if (e_rv && rr) begin
                mfly.push_back('{mpc, 1'b1});
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pend.push_back('{due, mpc});
                last_due = due;
                mpc += 32'd4;
            end
            if (rd) begin
                mbuf.delete();
                foreach (mfly[i]) mfly[i].live = 1'b0;
                mpc = rpc & ~32'h3;
            end
            mrun = 1'b1;
        end
        cyc++;
    endtask

    task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
        imem_req_ready = rr;
        inst_ready     = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update(rr, ir, rd, rpc);
        #1;
    endtask

    initial begin
        vec_t tv[$];
        bit   found;

        // Cycle-by-cycle expectations with 1-cycle memory latency, starting at reset release.
        tv.push_back(v(1,1,0,0, 0,32'h0,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h0,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h4,0,32'h0));
        tv.push_back(v(0,1,0,0, 1,32'h8,1,32'h0));
        tv.push_back(v(0,1,0,0, 1,32'h8,1,32'h4));
        repeat (3) tv.push_back(v(0,1,0,0, 1,32'h8,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h8,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'hC,0,32'h0));
        repeat (10) tv.push_back(v(1,0,0,0, 0,32'h10,1,32'h8));
        tv.push_back(v(1,1,0,0, 1,32'h10,1,32'h8));
        tv.push_back(v(1,1,0,0, 1,32'h14,1,32'hC));
        tv.push_back(v(1,1,0,0, 1,32'h18,1,32'h10));
        tv.push_back(v(1,1,1,32'h203, 1,32'h1C,1,32'h14));
        tv.push_back(v(1,1,0,0, 1,32'h200,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h204,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h208,1,32'h200));
        tv.push_back(v(1,1,1,32'hFFFF_FFFE, 1,32'h20C,1,32'h204));
        tv.push_back(v(1,1,0,0, 1,32'hFFFF_FFFC,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h0,0,32'h0));
        tv.push_back(v(1,1,0,0, 1,32'h4,1,32'hFFFF_FFFC));
        tv.push_back(v(1,1,0,0, 1,32'h8,1,32'h0));

        n_total = 0; n_bad = 0; cyc = 0; lat = 1; last_due = 0;
        m_init = 1'b0; mrun = 1'b0; mpc = RESET_PC; mstall = '0; mflush = '0;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
        @(posedge clk);
        #1;
        step(0,0,0,0);
        step(0,0,0,0);
        chk("rst_req_valid", {31'd0, s_rv}, 32'd0);
        chk("rst_req_addr", s_addr, RESET_PC);
        chk("rst_inst_valid", {31'd0, s_iv}, 32'd0);
        rst = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].rr, tv[i].ir, tv[i].rd, tv[i].rpc);
            chk("t_req_valid", {31'd0, s_rv}, {31'd0, tv[i].erv});
            chk("t_req_addr", s_addr, tv[i].ea);
            chk("t_inst_valid", {31'd0, s_iv}, {31'd0, tv[i].eiv});
            chk("t_inst_pc", s_ipc, tv[i].eipc);
            chk("t_inst_data", s_idat, tv[i].eiv ? mem_word(tv[i].eipc) : 32'h0);
        end

        // Slow memory with both slots in flight, then redirect: stale data must never surface.
        lat = 3;
        for (int k = 0; k < 20 && mfly.size() < 2; k++) step(1,1,0,0);
        step(1,1,1,32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1,1,0,0);
            if (s_iv) begin
                found = 1'b1;
                chk("redir_first_pc", s_ipc, 32'h100);
                chk("redir_first_data", s_idat, mem_word(32'h100));
            end
        end
        if (!found) begin
            n_total++; n_bad++;
            $display("FAIL redir_timeout cyc=%0d got=no_inst exp=inst_at_100", cyc);
        end
        lat = 1;

`ifdef FETCH_PERF_CNT_EN
        rst = 1'b0;
        step(0,0,0,0);
        step(0,0,0,0);
        rst = 1'b1;
        repeat (4) step(0,1,0,0);
        repeat (2) step(0,0,1,32'h40);
        step(0,0,0,0);
        chk("perf_stall", s_stall, 32'd4);
        chk("perf_flush", {16'd0, s_flush}, 32'd2);
`endif

        for (int c = 0; c < 3000; c++) begin
            lat = $urandom_range(1, 4);
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0, $urandom);
        end
        rst = 1'b1;
        repeat (10) step(1,1,0,0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
